// File: rtl/ntt_pkg.sv
// Shared definitions for the (I)NTT layer scheduler: transform geometry,
// scheduler state encoding and the per-layer twiddle base decode.
package ntt_pkg;

  localparam int unsigned NTT_N             = 256;
  localparam int unsigned NTT_HALF_NUM_BFU  = 16;
  localparam int unsigned NTT_NUM_LAYERS    = 7;
  localparam int unsigned ZETA_W            = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // NTT walks the twiddle tree forward (1<<layer), INTT walks it backward.
  function automatic logic [ZETA_W-1:0] zeta_of(input logic intt, input int unsigned layer);
    logic [ZETA_W-1:0] full;
    full = '1;
    if (intt) return full >> layer;
    return ZETA_W'(1) << layer;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-depth valid+address shift register with asynchronous reset; aligns
// write-backs (or twiddles) with the BFU pipeline latency.
module ntt_wb_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         d_valid,
  input  logic [W-1:0] d_addr,
  output logic         q_valid,
  output logic [W-1:0] q_addr
);

  logic         valid_sr [DEPTH];
  logic [W-1:0] addr_sr  [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_sr[i] <= 1'b0;
        addr_sr[i]  <= '0;
      end
    end else begin
      valid_sr[0] <= d_valid;
      addr_sr[0]  <= d_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        addr_sr[i]  <= addr_sr[i-1];
      end
    end
  end

  assign q_valid = valid_sr[DEPTH-1];
  assign q_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/ntt_layer_sched.sv
// Layer scheduler for the 32-BFU (I)NTT datapath: issues bank row reads,
// permute/zeta controls and latency-aligned write-backs for one polynomial.
import ntt_pkg::*;

module ntt_layer_sched #(
  parameter int unsigned HALF_NUM_BFU = NTT_HALF_NUM_BFU,
  parameter int unsigned NUM_LAYERS   = NTT_NUM_LAYERS,
  parameter int unsigned ROWS         = NTT_N / (4 * HALF_NUM_BFU),
  parameter int unsigned BFU_LAT      = 4,
  parameter int unsigned PERM_LAYERS  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_intt,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_rd_en,
  output logic [$clog2(ROWS)-1:0]       o_rd_addr,
  output logic                          o_wr_en,
  output logic [$clog2(ROWS)-1:0]       o_wr_addr,
  output logic [$clog2(NUM_LAYERS)-1:0] o_layer,
  output logic                          o_intt,
  output logic                          o_permute,
  output logic [ZETA_W-1:0]             o_zeta_base
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned LW = $clog2(NUM_LAYERS);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] READ  = ST_READ;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]        state;
  logic [RW-1:0]     row;
  logic [LW-1:0]     layer;
  logic              intt;
  logic [ZETA_W-1:0] zeta;

  logic              rd_en;
  logic [RW-1:0]     rd_addr;
  logic              wr_en;
  logic [RW-1:0]     wr_addr;
  logic              last_wr;

  always_comb begin
    rd_en   = (state == READ);
    rd_addr = rd_en ? row : '0;
    last_wr = wr_en && (wr_addr == LAST_ROW);
  end

  // DRAIN leaves on the final write of the layer, so the next layer's first
  // read can never overtake a pending write-back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      row   <= '0;
      layer <= '0;
      intt  <= 1'b0;
      zeta  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            intt  <= i_intt;
            layer <= '0;
            row   <= '0;
            zeta  <= zeta_of(i_intt, 0);
            state <= READ;
          end
        end
        READ: begin
          if (row == LAST_ROW) begin
            row   <= '0;
            state <= DRAIN;
          end else begin
            row <= row + 1'b1;
          end
        end
        DRAIN: begin
          if (last_wr) begin
            if (layer == LAST_LAYER) begin
              state <= DONE;
            end else begin
              layer <= layer + 1'b1;
              zeta  <= zeta_of(intt, 32'(layer) + 1);
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ntt_wb_delay #(
    .DEPTH (BFU_LAT),
    .W     (RW)
  ) u_wb_delay (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .d_valid (rd_en),
    .d_addr  (rd_addr),
    .q_valid (wr_en),
    .q_addr  (wr_addr)
  );

  always_comb begin
    o_busy      = (state == READ) || (state == DRAIN);
    o_done      = (state == DONE);
    o_rd_en     = rd_en;
    o_rd_addr   = rd_addr;
    o_wr_en     = wr_en;
    o_wr_addr   = wr_addr;
    o_layer     = layer;
    o_intt      = intt;
    o_permute   = rd_en && intt && (32'(layer) < PERM_LAYERS);
    o_zeta_base = zeta;
  end

endmodule

// File: tb/tb_ntt_layer_sched.sv
// Scoreboard bench for ntt_layer_sched at BFU_LAT 4 (default), 1 and 8,
// all three instances sharing one stimulus stream.
module tb_ntt_layer_sched;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  addr;
    logic [2:0]  layer;
    logic [6:0]  zeta;
    logic        intt;
    logic        perm;
  } rd_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  addr;
  } wr_t;

  function automatic int unsigned lat_of(input int g);
    if (g == 0) return 4;
    if (g == 1) return 1;
    return 8;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic intt_in;

  logic       busy_w [3];
  logic       done_w [3];
  logic       rd_en_w [3];
  logic [1:0] rd_addr_w [3];
  logic       wr_en_w [3];
  logic [1:0] wr_addr_w [3];
  logic [2:0] layer_w [3];
  logic       intt_w [3];
  logic       perm_w [3];
  logic [6:0] zeta_w [3];

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic        final_chk = 1'b0;
  logic        mon_done = 1'b0;

  rd_t         rd_q [3][$];
  wr_t         wr_q [3][$];
  int unsigned done_q [3][$];
  int unsigned next_free [3];

  logic [6:0] zeta_ntt  [7] = '{7'd1, 7'd2, 7'd4, 7'd8, 7'd16, 7'd32, 7'd64};
  logic [6:0] zeta_intt [7] = '{7'd127, 7'd63, 7'd31, 7'd15, 7'd7, 7'd3, 7'd1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ntt_layer_sched #(.BFU_LAT(lat_of(g))) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_intt      (intt_in),
      .o_busy      (busy_w[g]),
      .o_done      (done_w[g]),
      .o_rd_en     (rd_en_w[g]),
      .o_rd_addr   (rd_addr_w[g]),
      .o_wr_en     (wr_en_w[g]),
      .o_wr_addr   (wr_addr_w[g]),
      .o_layer     (layer_w[g]),
      .o_intt      (intt_w[g]),
      .o_permute   (perm_w[g]),
      .o_zeta_base (zeta_w[g])
    );
  end

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lat=%0d cycle %0d: got %0d, expected %0d", name, lat_of(g), cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a read, write or done.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        check("reset_outputs_zero", g,
              32'({rd_en_w[g], rd_addr_w[g], wr_en_w[g], wr_addr_w[g], layer_w[g],
                   intt_w[g], perm_w[g], zeta_w[g], busy_w[g], done_w[g]}), 32'd0);
      end else begin
        if (rd_en_w[g]) begin
          if (rd_q[g].size() == 0) begin
            check("rd_unexpected", g, 32'(rd_q[g].size()), 32'd1);
          end else begin
            rd_t e;
            e = rd_q[g].pop_front();
            check("rd_cycle", g, cyc, e.cyc);
            check("rd_addr", g, 32'(rd_addr_w[g]), 32'(e.addr));
            check("rd_layer", g, 32'(layer_w[g]), 32'(e.layer));
            check("rd_zeta", g, 32'(zeta_w[g]), 32'(e.zeta));
            check("rd_intt", g, 32'(intt_w[g]), 32'(e.intt));
            check("rd_permute", g, 32'(perm_w[g]), 32'(e.perm));
            check("rd_busy", g, 32'(busy_w[g]), 32'd1);
          end
        end else begin
          check("permute_without_read", g, 32'(perm_w[g]), 32'd0);
        end
        if (wr_en_w[g]) begin
          if (wr_q[g].size() == 0) begin
            check("wr_unexpected", g, 32'(wr_q[g].size()), 32'd1);
          end else begin
            wr_t w;
            w = wr_q[g].pop_front();
            check("wr_cycle", g, cyc, w.cyc);
            check("wr_addr", g, 32'(wr_addr_w[g]), 32'(w.addr));
          end
        end
        if (done_w[g]) begin
          if (done_q[g].size() == 0) begin
            check("done_unexpected", g, 32'(done_q[g].size()), 32'd1);
          end else begin
            check("done_cycle", g, cyc, done_q[g].pop_front());
            check("done_busy", g, 32'(busy_w[g]), 32'd0);
          end
        end
      end
    end
    if (final_chk && !mon_done) begin
      for (int g = 0; g < 3; g++) begin
        check("rd_missing", g, 32'(rd_q[g].size()), 32'd0);
        check("wr_missing", g, 32'(wr_q[g].size()), 32'd0);
        check("done_missing", g, 32'(done_q[g].size()), 32'd0);
      end
      mon_done = 1'b1;
    end
  end

  task automatic at_cycle(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle start pulse; instances that are idle get the full expected run queued.
  task automatic pulse(input logic mode);
    int unsigned c;
    c = cyc;
    start = 1'b1;
    intt_in = mode;
    for (int g = 0; g < 3; g++) begin
      int unsigned lat;
      lat = lat_of(g);
      if (c >= next_free[g]) begin
        for (int l = 0; l < 7; l++) begin
          for (int r = 0; r < 4; r++) begin
            int unsigned rc;
            rc = c + 1 + l * (4 + lat) + r;
            rd_q[g].push_back('{cyc: rc, addr: 2'(r), layer: 3'(l),
                                zeta: mode ? zeta_intt[l] : zeta_ntt[l],
                                intt: mode, perm: mode && (l < 4)});
            wr_q[g].push_back('{cyc: rc + lat, addr: 2'(r)});
          end
        end
        done_q[g].push_back(c + 7 * (4 + lat) + 1);
        next_free[g] = c + 7 * (4 + lat) + 2;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int unsigned c0;
    int unsigned c1;
    int unsigned c2;
    rst_n = 1'b0;
    start = 1'b0;
    intt_in = 1'b0;
    for (int g = 0; g < 3; g++) next_free[g] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // NTT run, ignored starts while busy and in DONE, then INTT run with i_intt toggling
    @(posedge clk);
    #1;
    c0 = cyc;
    pulse(1'b0);
    at_cycle(c0 + 10);
    pulse(1'b0);
    at_cycle(c0 + 57);
    pulse(1'b0);
    at_cycle(c0 + 58);
    pulse(1'b1);
    at_cycle(c0 + 70);
    intt_in = 1'b0;
    at_cycle(c0 + 80);
    intt_in = 1'b1;
    at_cycle(c0 + 95);
    intt_in = 1'b0;
    at_cycle(c0 + 130);

    // Asynchronous reset mid-DRAIN aborts the run, then a clean restart
    c1 = cyc;
    pulse(1'b0);
    at_cycle(c1 + 22);
    #2;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      rd_q[g].delete();
      wr_q[g].delete();
      done_q[g].delete();
      next_free[g] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    c2 = cyc;
    pulse(1'b0);
    at_cycle(c2 + 100);

    final_chk = 1'b1;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
